uart_rx_ctrl: RTL and testbench

Receive-path controller for the UART RX, placed directly downstream of the edge/bit counter. It consumes the counter's `edge_count`/`bit_count` and drives the counter's enable. It majority-samples the 8x-oversampled serial line, deserializes LSB-first data, and checks the start, parity and stop bits. It delivers each good byte with a one-cycle `data_valid` pulse, or flags a parity or stop error.

---
 rtl/uart_rx_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller with 8x majority sampling.
// Deserializes LSB-first frames and checks start, parity and stop bits.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [2:0]            edge_count,
  input  logic [3:0]            bit_count,
  output logic                  cnt_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t                state;
  logic                  s3, s4, s5;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  xacc;
  logic                  perr;
  logic                  serr;
  logic                  pe_q;
  logic                  pt_q;
  logic                  bit_val;
  logic                  last_edge;
  logic                  last_data;
  logic                  par_bad;
  logic                  stop_bad;

  assign bit_val   = (s3 & s4) | (s3 & s5) | (s4 & s5);
  assign last_edge = (edge_count == 3'd7);
  assign last_data = (bit_count == 4'(DATA_WIDTH));
  assign par_bad   = bit_val != (xacc ^ pt_q);
  assign stop_bad  = ~bit_val;

  assign cnt_en = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);
  assign busy   = (state != IDLE);

  // Capture the three mid-bit samples used for the majority vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3 <= 1'b0;
      s4 <= 1'b0;
      s5 <= 1'b0;
    end else begin
      if (edge_count == 3'd3) s3 <= rx_in;
      if (edge_count == 3'd4) s4 <= rx_in;
      if (edge_count == 3'd5) s5 <= rx_in;
    end
  end

  // Frame FSM; result pulses are registered so they coincide with DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      xacc       <= 1'b0;
      perr       <= 1'b0;
      serr       <= 1'b0;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_in) begin
            state <= START;
            pe_q  <= par_en;
            pt_q  <= par_typ;
          end
        end
        START: begin
          if (last_edge) begin
            state <= bit_val ? IDLE : DATA;
          end
        end
        DATA: begin
          if (last_edge) begin
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            xacc  <= xacc ^ bit_val;
            if (last_data) begin
              state <= pe_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (last_edge) begin
            if (par_bad) perr <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            serr     <= stop_bad;
            par_err  <= perr;
            stop_err <= stop_bad;
            if (!perr && !stop_bad) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          perr  <= 1'b0;
          serr  <= 1'b0;
          shreg <= '0;
          xacc  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against a scoreboard of result pulses.
// Models the upstream edge/bit counter from cnt_en.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [2:0] edge_count = 3'd0;
  logic [3:0] bit_count = 4'd0;
  logic       cnt_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       busy;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } exp_t;

  exp_t       sbq[$];
  int         cycle = 0;
  int         n_total = 0;
  int         n_pass = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .edge_count (edge_count),
    .bit_count  (bit_count),
    .cnt_en     (cnt_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Edge/bit counter model.
  always @(posedge clk) begin
    if (!cnt_en) begin
      edge_count <= 3'd0;
      bit_count  <= 4'd0;
    end else if (edge_count == 3'd7) begin
      edge_count <= 3'd0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: observe this cycle's outputs, drive this cycle's inputs.
  task automatic cyc(input logic rx, input logic r);
    exp_t e;
    @(negedge clk);
    cycle++;
    if (data_valid || par_err || stop_err) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {29'd0, data_valid, par_err, stop_err}, 0);
      end else begin
        e = sbq.pop_front();
        chk("pulse_cycle", cycle, e.cyc);
        chk("data_valid", data_valid, e.dv);
        chk("par_err", par_err, e.pe);
        chk("stop_err", stop_err, e.se);
        chk("data_out", data_out, e.d);
      end
    end
    rx_in = rx;
    rst   = r;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe,
                            input logic pt, input logic pbit,
                            input logic stopb, input int flip_bit,
                            input int abort_at);
    logic bits[11];
    int   n;
    int   t0;
    int   j;
    int   bad;
    logic rx;
    logic perr;
    logic serr;
    exp_t e;
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[n++] = d[i];
    if (pe) bits[n++] = pbit;
    bits[n++] = stopb;
    par_en  = pe;
    par_typ = pt;
    t0   = cycle + 1;
    perr = pe && (pbit != ((^d) ^ pt));
    serr = !stopb;
    if (abort_at == 0) begin
      e.cyc = t0 + 8 * n + 1;
      e.dv  = !perr && !serr;
      e.pe  = perr;
      e.se  = serr;
      e.d   = e.dv ? d : last_good;
      sbq.push_back(e);
      if (e.dv) last_good = d;
    end
    bad = 0;
    for (int k = 0; k <= 8 * n + 1; k++) begin
      if (k == 0) begin
        rx = 1'b0;
      end else begin
        j  = (k - 1) / 8;
        rx = (j < n) ? bits[j] : 1'b1;
        if (flip_bit >= 0 && k == 1 + 8 * (flip_bit + 1) + 4) rx = ~rx;
      end
      cyc(rx, k == abort_at && abort_at != 0);
      if (busy !== (k >= 1)) bad++;
      if (cnt_en !== (k >= 1 && k <= 8 * n)) bad++;
      if (k == abort_at && abort_at != 0) begin
        cyc(1'b1, 1'b0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_pulses", {29'd0, data_valid, par_err, stop_err}, 0);
        last_good = 8'h00;
        break;
      end
    end
    chk("busy_cnt_en_window", bad, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  initial begin
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("reset_busy", busy, 0);
    chk("reset_cnt_en", cnt_en, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_pulses", {29'd0, data_valid, par_err, stop_err}, 0);
    idle(2);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(2);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    idle(2);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    idle(2);

    cyc(1'b0, 1'b0);
    chk("glitch_t0_busy", busy, 0);
    cyc(1'b0, 1'b0);
    for (int k = 2; k <= 10; k++) begin
      cyc(1'b1, 1'b0);
      if (k == 8) chk("glitch_t8_busy", busy, 1);
      if (k == 9) begin
        chk("glitch_t9_busy", busy, 0);
        chk("glitch_t9_cnt_en", cnt_en, 0);
      end
    end
    idle(2);

    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 30);
    idle(3);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(2);

    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(4);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
